// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared widths and 2-bit counter encoding for the branch predictor
//   Provides default PC/statistics widths, BTB depth and the saturating-counter states.
package branch_predictor_pkg;

  localparam int BP_PC_WIDTH = 32;
  localparam int BP_ENTRIES  = 16;
  localparam int BP_CNT_W    = 32;

  // Counter states; bit 1 is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_cnt_e;

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup / EX training / statistics bundle for the branch predictor
//   master : pipeline side, drives IF_PC and the EX resolution, receives prediction and stats.
//   slave  : predictor side.
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int PC_WIDTH = BP_PC_WIDTH,
  parameter int CNT_W    = BP_CNT_W
);

  logic [PC_WIDTH-1:0] IF_PC;
  logic                Predict_Taken;
  logic [PC_WIDTH-1:0] Predict_PC;

  logic                EX_Valid;
  logic                EX_Branch;
  logic                EX_Jal;
  logic [PC_WIDTH-1:0] EX_PC;
  logic                EX_Taken;
  logic [PC_WIDTH-1:0] EX_Target;
  logic                EX_Predict_Taken;
  logic [PC_WIDTH-1:0] EX_Predict_PC;

  logic                Mispredict;
  logic [CNT_W-1:0]    Branch_Count;
  logic [CNT_W-1:0]    Mispredict_Count;

  modport master (
    output IF_PC, EX_Valid, EX_Branch, EX_Jal, EX_PC, EX_Taken, EX_Target,
           EX_Predict_Taken, EX_Predict_PC,
    input  Predict_Taken, Predict_PC, Mispredict, Branch_Count, Mispredict_Count
  );

  modport slave (
    input  IF_PC, EX_Valid, EX_Branch, EX_Jal, EX_PC, EX_Taken, EX_Target,
           EX_Predict_Taken, EX_Predict_PC,
    output Predict_Taken, Predict_PC, Mispredict, Branch_Count, Mispredict_Count
  );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// rtl/branch_predictor_sat_counter.sv - combinational 2-bit saturating counter next state
//   cnt      in  current counter state
//   taken    in  resolved direction
//   cnt_next out counter state after training
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_cnt_e cnt,
  input  logic    taken,
  output bp_cnt_e cnt_next
);

  always_comb begin
    cnt_next = cnt;
    unique case (cnt)
      BP_SNT: cnt_next = taken ? BP_WNT : BP_SNT;
      BP_WNT: cnt_next = taken ? BP_WT  : BP_SNT;
      BP_WT:  cnt_next = taken ? BP_ST  : BP_WNT;
      BP_ST:  cnt_next = taken ? BP_ST  : BP_WT;
      default: cnt_next = cnt;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, misprediction flag and statistics
//   clk, rst : clock and asynchronous active-high reset
//   bp       : branch_predictor_if.slave (IF lookup, EX training, Mispredict, counters)
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PC_WIDTH = BP_PC_WIDTH,
  parameter int ENTRIES  = BP_ENTRIES,
  parameter int CNT_W    = BP_CNT_W
) (
  input logic              clk,
  input logic              rst,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  logic                valid_q [ENTRIES];
  logic [TAG_W-1:0]    tag_q   [ENTRIES];
  bp_cnt_e             cnt_q   [ENTRIES];
  logic [PC_WIDTH-1:0] tgt_q   [ENTRIES];

  logic [CNT_W-1:0]    br_cnt_q;
  logic [CNT_W-1:0]    mp_cnt_q;

  logic [IDX_W-1:0]    if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                if_hit, ex_hit;
  logic                upd, taken_eff, mispredict;
  bp_cnt_e             cnt_next;
  logic                unused_lsbs;

  // Instruction alignment bits carry no information for the BTB.
  assign unused_lsbs = ^{bp.IF_PC[1:0], bp.EX_PC[1:0]};

  assign if_idx = bp.IF_PC[IDX_W+1:2];
  assign if_tag = bp.IF_PC[PC_WIDTH-1:IDX_W+2];
  assign ex_idx = bp.EX_PC[IDX_W+1:2];
  assign ex_tag = bp.EX_PC[PC_WIDTH-1:IDX_W+2];

  // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
  assign if_hit           = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bp.Predict_Taken = if_hit && cnt_q[if_idx][1];
  assign bp.Predict_PC    = bp.Predict_Taken ? tgt_q[if_idx] : bp.IF_PC + PC_WIDTH'(4);

  assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd       = bp.EX_Valid && (bp.EX_Branch || bp.EX_Jal);
  // A JAL is unconditionally taken whatever EX_Taken says.
  assign taken_eff = bp.EX_Jal || bp.EX_Taken;

  assign mispredict = upd && ((bp.EX_Predict_Taken != taken_eff) ||
                              (taken_eff && (bp.EX_Predict_PC != bp.EX_Target)));
  assign bp.Mispredict       = mispredict;
  assign bp.Branch_Count     = br_cnt_q;
  assign bp.Mispredict_Count = mp_cnt_q;

  bp_sat_counter u_sat_counter (
    .cnt      (cnt_q[ex_idx]),
    .taken    (bp.EX_Taken),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= BP_WNT;
        tgt_q[i]   <= '0;
      end
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else if (upd) begin
      if (bp.EX_Jal) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        cnt_q[ex_idx]   <= BP_ST;
        tgt_q[ex_idx]   <= bp.EX_Target;
      end else if (ex_hit) begin
        cnt_q[ex_idx] <= cnt_next;
        if (bp.EX_Taken) begin
          tgt_q[ex_idx] <= bp.EX_Target;
        end
      end else if (bp.EX_Taken) begin
        // Taken miss replaces whatever lived at this index; a not-taken miss leaves it alone.
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        cnt_q[ex_idx]   <= BP_WT;
        tgt_q[ex_idx]   <= bp.EX_Target;
      end

      if (br_cnt_q != '1) begin
        br_cnt_q <= br_cnt_q + CNT_W'(1);
      end
      if (mispredict && (mp_cnt_q != '1)) begin
        mp_cnt_q <= mp_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
